// File: rtl/rgb_led_pwm.sv
// rgb_led_pwm: PWM driver for an active-low RGB LED.
// A colour arrives over a valid/ready handshake, waits in a pending register
// and is copied into the active duty registers only on the period wrap, so
// every PWM period is driven by a single, consistent duty set.
// Optional blink overlay: define RGB_LED_BLINK_EN to build it.
//
// Handshake FSM
//   state   | meaning
//   IDLE    | ready for a colour; color_ready = 1
//   PENDING | colour latched, waiting for the next wrap to apply it
module rgb_led_pwm #(
   parameter int PWM_BITS = 8,
   parameter int CLK_HZ   = 12000000,
   parameter int BLINK_HZ = 2
) (
   input  logic                pin_clk_12mhz,
   input  logic                rst,
   input  logic                color_valid,
   output logic                color_ready,
   input  logic [PWM_BITS-1:0] color_r,
   input  logic [PWM_BITS-1:0] color_g,
   input  logic [PWM_BITS-1:0] color_b,
   input  logic                blink,
   output logic                red,
   output logic                green,
   output logic                blue
);

   // Last count of the period: 2^PWM_BITS-2, giving a 2^PWM_BITS-1 slot period
   // so that full-scale duty lights every slot.
   localparam logic [PWM_BITS-1:0] CNT_WRAP = {{(PWM_BITS-1){1'b1}}, 1'b0};

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [PWM_BITS-1:0] cnt;
   logic                wrap;
   logic                load_pend;
   logic                apply;
   logic [PWM_BITS-1:0] pend_r;
   logic [PWM_BITS-1:0] pend_g;
   logic [PWM_BITS-1:0] pend_b;
   logic [PWM_BITS-1:0] duty_r;
   logic [PWM_BITS-1:0] duty_g;
   logic [PWM_BITS-1:0] duty_b;
   logic                force_off;

   assign wrap = (cnt == CNT_WRAP);

   // Period counter: 0 .. CNT_WRAP, then back to 0.
   always_ff @(posedge pin_clk_12mhz or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (wrap) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Handshake state register.
   always_ff @(posedge pin_clk_12mhz or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state, ready, and load/apply strobes.
   always_comb begin
      state_nxt   = state;
      color_ready = 1'b0;
      load_pend   = 1'b0;
      apply       = 1'b0;
      case (state)
         IDLE: begin
            color_ready = 1'b1;
            if (color_valid) begin
               load_pend = 1'b1;
               state_nxt = PENDING;
            end
         end
         PENDING: begin
            // A colour taken on the wrap cycle lands here one cycle later,
            // so it naturally waits for the following wrap.
            if (wrap) begin
               apply     = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Pending colour, captured only on an accepted handshake.
   always_ff @(posedge pin_clk_12mhz or posedge rst) begin
      if (rst) begin
         pend_r <= '0;
         pend_g <= '0;
         pend_b <= '0;
      end else if (load_pend) begin
         pend_r <= color_r;
         pend_g <= color_g;
         pend_b <= color_b;
      end
   end

   // Active duty, updated only at the period boundary.
   always_ff @(posedge pin_clk_12mhz or posedge rst) begin
      if (rst) begin
         duty_r <= '0;
         duty_g <= '0;
         duty_b <= '0;
      end else if (apply) begin
         duty_r <= pend_r;
         duty_g <= pend_g;
         duty_b <= pend_b;
      end
   end

`ifdef RGB_LED_BLINK_EN
   localparam int BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
   localparam int BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [BLINK_W-1:0] BLINK_RELOAD = BLINK_W'(BLINK_HALF - 1);

   logic [BLINK_W-1:0] blink_cnt;
   logic               phase;

   // Blink phase timer: down-counter, toggles phase at terminal count.
   always_ff @(posedge pin_clk_12mhz or posedge rst) begin
      if (rst) begin
         blink_cnt <= BLINK_RELOAD;
         phase     <= 1'b0;
      end else if (blink_cnt == '0) begin
         blink_cnt <= BLINK_RELOAD;
         phase     <= ~phase;
      end else begin
         blink_cnt <= blink_cnt - 1'b1;
      end
   end

   assign force_off = blink & phase;
`else
   // Overlay not built: this reduces to constant 0, blink has no effect.
   assign force_off = blink & (CLK_HZ < 0) & (BLINK_HZ < 0);
`endif

   // Registered, inverted pins; force_off shares the same register.
   always_ff @(posedge pin_clk_12mhz or posedge rst) begin
      if (rst) begin
         red   <= 1'b1;
         green <= 1'b1;
         blue  <= 1'b1;
      end else begin
         red   <= ~(cnt < duty_r) | force_off;
         green <= ~(cnt < duty_g) | force_off;
         blue  <= ~(cnt < duty_b) | force_off;
      end
   end

endmodule

// File: tb/tb_rgb_led_pwm.sv
// Directed bench for rgb_led_pwm (PWM_BITS = 8, CLK_HZ = 1200, BLINK_HZ = 2).
// k counts clock edges since reset release; the expected period count is k % 255.
module tb_rgb_led_pwm;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       valid = 1'b0;
   logic       ready;
   logic [7:0] cr = '0;
   logic [7:0] cg = '0;
   logic [7:0] cb = '0;
   logic       blink = 1'b0;
   logic       red, green, blue;

   int n_chk  = 0;
   int n_fail = 0;
   int k      = 0;

   rgb_led_pwm #(
      .PWM_BITS (8),
      .CLK_HZ   (1200),
      .BLINK_HZ (2)
   ) dut (
      .pin_clk_12mhz (clk),
      .rst           (rst),
      .color_valid   (valid),
      .color_ready   (ready),
      .color_r       (cr),
      .color_g       (cg),
      .color_b       (cb),
      .blink         (blink),
      .red           (red),
      .green         (green),
      .blue          (blue)
   );

   always #5 clk = ~clk;

   // Edge count since release of reset.
   always @(posedge clk or posedge rst) begin
      if (rst) k <= 0;
      else     k <= k + 1;
   end

   function automatic int cnt_m();
      return k % 255;
   endfunction

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wait_cnt(input int c);
      int n = 0;
      while (cnt_m() != c && n < 300) begin
         step();
         n++;
      end
      if (n >= 300) chk("wait_cnt", cnt_m(), c);
   endtask

   task automatic send_at(input int c, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      wait_cnt(c);
      cr = r;
      cg = g;
      cb = b;
      valid = 1'b1;
      step();
      valid = 1'b0;
   endtask

   // Lit-slot counts over one whole period (pins reflecting cnt 0..254).
   task automatic measure(output int nr, output int ng, output int nb, output int nh);
      nr = 0; ng = 0; nb = 0; nh = 0;
      wait_cnt(1);
      repeat (255) begin
         if (!red)   nr++;
         if (!green) ng++;
         if (!blue)  nb++;
         if (valid && ready) nh++;
         step();
      end
   endtask

   task automatic idle_check(input string tag);
      int bad  = 0;
      int nrdy = 0;
      repeat (600) begin
         step();
         if ({red, green, blue} != 3'b111) bad++;
         if (!ready) nrdy++;
      end
      chk(tag, bad, 0);
      chk({tag, "_rdy"}, nrdy, 0);
   endtask

   initial begin
      int nr, ng, nb, nh;
      int errs, n_off, n;

      // Power-on reset
      rst = 1'b1;
      step();
      step();
      chk("rst_pins", {red, green, blue}, 3'b111);
      chk("rst_rdy", ready, 1);
      rst = 1'b0;
      idle_check("rst_idle");

      // Full-on / off / half
      send_at(10, 8'd255, 8'd0, 8'd128);
      chk("full_rdy_low", ready, 0);
      wait_cnt(254);
      chk("full_rdy_wrap", ready, 0);
      step();
      chk("full_rdy_back", ready, 1);
      measure(nr, ng, nb, nh);
      chk("full_red", nr, 255);
      chk("full_green", ng, 0);
      chk("full_blue", nb, 128);

      // Boundary alignment: r = 64 at cnt 100
      send_at(100, 8'd64, 8'd0, 8'd128);
      chk("bnd_rdy", ready, 0);
      wait_cnt(120);
      chk("bnd_old_mid", red, 0);
      wait_cnt(0);
      chk("bnd_old_last", red, 0);
      wait_cnt(64);
      chk("bnd_new_63", red, 0);
      step();
      chk("bnd_new_64", red, 1);
      measure(nr, ng, nb, nh);
      chk("bnd_period", nr, 64);

      // Wrap collision: handshake on cnt 254
      send_at(254, 8'd30, 8'd0, 8'd128);
      chk("wrap_rdy", ready, 0);
      measure(nr, ng, nb, nh);
      chk("wrap_first", nr, 64);
      measure(nr, ng, nb, nh);
      chk("wrap_next", nr, 30);

      // Back-to-back with valid held high
      wait_cnt(50);
      cr = 8'd10;
      valid = 1'b1;
      step();
      chk("b2b_rdy", ready, 0);
      cr = 8'd200;
      measure(nr, ng, nb, nh);
      chk("b2b_first", nr, 10);
      chk("b2b_acc1", nh, 1);
      measure(nr, ng, nb, nh);
      chk("b2b_second", nr, 200);
      chk("b2b_acc2", nh, 1);
      valid = 1'b0;

      // Reset mid-period while a colour is pending
      wait_cnt(1);
      send_at(100, 8'd255, 8'd255, 8'd255);
      chk("pre_rst_red", red, 0);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_pins", {red, green, blue}, 3'b111);
      chk("mid_rst_rdy", ready, 1);
      step();
      step();
      rst = 1'b0;
      idle_check("mid_rst_idle");

      // Blink overlay
      send_at(10, 8'd255, 8'd255, 8'd255);
      wait_cnt(254);
      step();
      step();
      chk("blink_pre", {red, green, blue}, 3'b000);
      blink = 1'b1;
      errs = 0;
      n_off = 0;
`ifdef RGB_LED_BLINK_EN
      repeat (1200) begin
         step();
         if ({red, green, blue} != ((((k - 1) / 300) % 2 == 1) ? 3'b111 : 3'b000)) errs++;
         if ({red, green, blue} == 3'b111) n_off++;
      end
      chk("blink_pattern", errs, 0);
      chk("blink_off_cnt", n_off, 600);
      n = 0;
      while (!((((k - 1) / 300) % 2 == 1) && ((k / 300) % 2 == 1)) && n < 700) begin
         step();
         n++;
      end
      chk("blink_forced", {red, green, blue}, 3'b111);
      blink = 1'b0;
      step();
      chk("blink_release", {red, green, blue}, 3'b000);
`else
      repeat (600) begin
         step();
         if ({red, green, blue} != 3'b000) errs++;
      end
      chk("blink_ignored", errs, 0);
      blink = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rgb_led_pwm.md
# rgb_led_pwm

PWM driver for the on-board active-low RGB LED: takes an 8-bit-per-channel colour through a valid/ready handshake and produces glitch-free, period-aligned PWM on the `red`, `green` and `blue` pins. It is the output-side counterpart to the user-switch input path. It sits between status/control logic (button handlers, S/PDIF lock indicators) and the LED pins. It also provides a fixed-rate blink overlay that can be compiled in.

## Interface
Parameters:
- `PWM_BITS`, 8: duty width per channel; PWM period = 2^PWM_BITS − 1 clocks.
- `CLK_HZ`, 12000000: clock frequency; used only for blink timing.
- `BLINK_HZ`, 2: blink rate when blink is compiled in and enabled.

Ports:
- `pin_clk_12mhz`  in  1: system clock; the only clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `color_valid`  in  1: colour offer.
- `color_ready`  out  1: block can accept a colour.
- `color_r`  in  PWM_BITS: red duty; 0 = off, 2^PWM_BITS−1 = fully on.
- `color_g`  in  PWM_BITS: green duty.
- `color_b`  in  PWM_BITS: blue duty.
- `blink`  in  1: blink request; ignored unless `RGB_LED_BLINK_EN` is defined.
- `red`  out  1: red LED, active-low.
- `green`  out  1: green LED, active-low.
- `blue`  out  1: blue LED, active-low.

## Operation
- Period counter `cnt` counts 0 … 2^PWM_BITS−2, then wraps to 0. The wrap cycle is the one where `cnt` = 2^PWM_BITS−2.
- Active duty registers `duty_r/g/b` drive the PWM. Channel X is lit in a count slot when `cnt < duty_X`. Duty 0 never lights; duty 255 lights every slot of the 255-slot period.
- Pins are registered and inverted: `red <= ~(cnt < duty_r)`, and the same for the other channels.
- Handshake FSM, two states:
  - IDLE: `color_ready` = 1. If `color_valid` is high, latch `color_r/g/b` into pending registers and go to PENDING.
  - PENDING: `color_ready` = 0. On the wrap cycle, copy pending into active and go to IDLE.
- Transfer occurs only on `color_valid && color_ready`. Inputs are not sampled at any other time.
- The active duty changes only at a period boundary, so no period ever holds a mix of old and new duty.
- If a handshake lands on the wrap cycle itself, the colour is held pending and applied at the following wrap, not the current one.
- Holding `color_valid` high is allowed. A new colour is accepted every time the FSM returns to IDLE, at most once per PWM period.
- Reset asserted mid-period or while PENDING discards the pending colour.
- Reset values:
  - `cnt` = 0, duty registers = 0, pending registers = 0.
  - FSM = IDLE, so `color_ready` = 1.
  - `red` = `green` = `blue` = 1 (all LEDs off).
  - Blink phase = 0.

## Timing
- PWM period is 255 clocks at PWM_BITS = 8, which is ≈47.06 kHz at 12 MHz.
- Pin latency is one clock from `cnt`/duty to the pin.
- Handshake to visible colour: the colour is applied on the first wrap strictly after the handshake cycle. Pins show the new duty starting 2 clocks after that wrap cycle (`cnt` reaches 0, then the pin register updates).
- Worst-case handshake-to-visible latency is 255 + 2 clocks; best case is 3 clocks.
- `color_ready` deasserts the cycle after acceptance and reasserts the cycle after the wrap that applies the colour.
- Release of `rst` is asynchronous. The first counting edge is the first clock edge after deassertion.

## Configuration
- `RGB_LED_BLINK_EN`:
  - **Defined:** adds a phase counter that toggles `phase` every CLK_HZ/(2·BLINK_HZ) clocks (3,000,000 at the defaults). While `blink` = 1 and `phase` = 1, all three pins are forced to 1 (off) through the same output register. PWM counter and handshake keep running. When `blink` is deasserted, the forced-off state releases on the next clock.
  - **Undefined:** no phase counter is built and `blink` is unused. Behaviour is identical to the defined case with `blink` = 0.

## Test plan
- Reset: assert `rst` mid-period → within the same cycle `red/green/blue` = 1 and `color_ready` = 1. After release, all three pins stay at 1 for 600 clocks.
- Full-on and off: send r = 255, g = 0, b = 128 → from the first period after apply, `red` = 0 for 255/255 clocks, `green` = 1 for 255/255 clocks, `blue` = 0 for exactly 128 of every 255 clocks.
- Boundary alignment: handshake r = 64 at `cnt` = 100 → `color_ready` = 0 from the next cycle. The old duty persists through `cnt` = 254, and `red` first reflects 64 two clocks after the wrap.
- Wrap collision: handshake exactly on the wrap cycle → the colour is applied at the next wrap, 255 clocks later, with no partial period.
- Back-to-back: `color_valid` held high with values 10 then 200 → exactly one acceptance per period. Each colour is visible for at least one full period; value 200 is not lost.
- Blink (with `RGB_LED_BLINK_EN`, CLK_HZ = 1200, BLINK_HZ = 2): colour 255/255/255 with `blink` = 1 → pins alternate 300 clocks all-1 and 300 clocks all-0. Setting `blink` = 0 restores steady-on in 1 clock.
